sound_noise_channel: RTL
========================

SOUND_NOISE_CHANNEL -- requirements
Module: sound_noise_channel

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, output sample width, legal range 4..16.
REQ-002 SHALL have parameter TIMER_W, default 20, noise timer counter width, minimum 20.
REQ-003 SHALL have ports I_CLK  in  1  sole clock, all logic on rising edge; I_RESET_L  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports I_REG_ADDR  in  2  register select (0=NR41, 1=NR42, 2=NR43, 3=NR44); I_REG_DATA  in  8  write data; I_REG_WE  in  1  one-cycle write strobe.
REQ-005 SHALL have ports I_TICK_CH  in  1  timer-base enable; I_TICK_LEN  in  1  256 Hz length enable; I_TICK_ENV  in  1  64 Hz envelope enable (all single-cycle pulses).
REQ-006 SHALL have ports O_SAMPLE  out  SAMPLE_W  registered sample; O_ACTIVE  out  1  channel enabled; O_LFSR_BIT  out  1  current noise bit.

Function
REQ-007 SHALL decode fields: NR41[5:0] length L; NR42[7:4] initial volume, [3] direction (1=up), [2:0] envelope period P; NR43[7:4] shift s, [3] width mode, [2:0] divisor code r; NR44[7] trigger, [6] length enable.
REQ-008 SHALL compute timer period = D << s in I_TICK_CH pulses, D = 8 if r=0 else 16*r; s=14 or 15 SHALL stop LFSR clocking.
REQ-009 SHALL decrement the timer on each I_TICK_CH; at expiry reload period and step LFSR: x=lfsr[0]^lfsr[1], lfsr={x,lfsr[14:1]}; width mode also writes x into lfsr[6].
REQ-010 SHALL drive O_LFSR_BIT = ~lfsr[0].
REQ-011 SHALL load length counter with 64-L on NR41 write; on I_TICK_LEN with length enable and counter nonzero, decrement; reaching 0 SHALL clear O_ACTIVE next cycle.
REQ-012 SHALL treat DAC as on iff NR42[7:3] nonzero; NR42 write with DAC off SHALL clear O_ACTIVE next cycle.
REQ-013 SHALL on trigger: set O_ACTIVE iff DAC on, lfsr=15'h7FFF, reload timer, volume=initial, envelope timer=P, length counter=64 if currently 0.
REQ-014 SHALL on I_TICK_ENV with P nonzero decrement envelope timer; at 0 reload P and step volume +1/-1, saturating at 15/0.
REQ-015 SHALL register O_SAMPLE one cycle after state: O_ACTIVE and O_LFSR_BIT ? volume << (SAMPLE_W-4) : 0.
REQ-016 SHALL give trigger priority over same-cycle ticks on every counter; NR41 load SHALL override same-cycle length tick.
REQ-017 SHALL apply register writes while inactive; they take effect on next trigger except NR41 load and DAC-off.

Reset
REQ-018 SHALL on I_RESET_L low asynchronously clear all registers, counters, volume, O_SAMPLE, O_ACTIVE; lfsr=15'h7FFF, O_LFSR_BIT=0.
REQ-019 SHALL on reset mid-operation abandon state; first trigger after release behaves as REQ-013.

Configuration
REQ-020 SHALL with SND_NOISE_SIGNED_EN defined produce two's-complement O_SAMPLE: active ? (bit ? +vol : -vol) << (SAMPLE_W-5) : 0.
REQ-021 SHALL without SND_NOISE_SIGNED_EN produce unsigned output per REQ-015.

Structure
REQ-022 SHALL place register offsets, LFSR seed 15'h7FFF, and divisor-table function in shared package snd_pkg.
REQ-023 SHALL instantiate envelope (volume, timer, direction, saturation) as sub-module snd_envelope, reusable by pulse channels.

Verification
REQ-024 SHALL cover: NR42=F0, NR43=00, NR44=80, TICK_CH every cycle -> LFSR steps every 8 ticks, first bits 0x7FFF->0x3FFF, O_ACTIVE=1.
REQ-025 SHALL cover: NR43=08 width mode -> LFSR period 127 steps; NR43=F0 -> LFSR frozen.
REQ-026 SHALL cover: NR41=3E, NR44=C0, DAC on -> O_ACTIVE falls after 2nd I_TICK_LEN; NR44=80 -> never falls.
REQ-027 SHALL cover: NR42=0B (vol 0, up, P=3) trigger -> volume reaches 15 after 45 I_TICK_ENV then holds; O_SAMPLE max 8'hF0.
REQ-028 SHALL cover: trigger coincident with I_TICK_LEN/I_TICK_ENV -> counters take reload values; NR42=00 while active -> O_ACTIVE=0 next cycle.
REQ-029 SHALL cover: I_RESET_L pulsed mid-tone, asynchronously -> outputs 0 same edge, lfsr 0x7FFF; repeated with SND_NOISE_SIGNED_EN, vol 15, bit 0 -> O_SAMPLE=8'h88.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared sound-channel definitions: register offsets, LFSR seed and noise divisor table.
package snd_pkg;

  localparam logic [1:0]  ADDR_NR41 = 2'd0;
  localparam logic [1:0]  ADDR_NR42 = 2'd1;
  localparam logic [1:0]  ADDR_NR43 = 2'd2;
  localparam logic [1:0]  ADDR_NR44 = 2'd3;
  localparam logic [14:0] LFSR_SEED = 15'h7FFF;

  // Timer period in channel ticks: D << shift, D = 8 for code 0 else 16*code.
  function automatic logic [19:0] noise_period(input logic [3:0] shift, input logic [2:0] code);
    logic [19:0] base;
    base = (code == 3'd0) ? 20'd8 : {13'd0, code, 4'd0};
    return base << shift;
  endfunction

endpackage

// File: rtl/sound_noise_channel_if.sv
// Register-write bus and frame-sequencer tick strobes shared by sound channels.
interface sound_noise_channel_if;
  logic [1:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_we;
  logic       tick_ch;
  logic       tick_len;
  logic       tick_env;

  modport master (output reg_addr, reg_data, reg_we, tick_ch, tick_len, tick_env);
  modport slave  (input  reg_addr, reg_data, reg_we, tick_ch, tick_len, tick_env);
endinterface

// File: rtl/snd_envelope.sv
// Volume envelope: owns the NRx2 register, steps volume up/down every P envelope ticks with saturation.
module snd_envelope
  import snd_pkg::*;
#(
  parameter logic [1:0] REG_ADDR = ADDR_NR42
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sound_noise_channel_if.slave bus,
  input  logic                 trigger,
  output logic [3:0]           volume,
  output logic                 dac_on
);

  logic [7:0] nrx2_q, nrx2_d;
  logic [3:0] vol_q, vol_d;
  logic       up_q, up_d;
  logic [2:0] period_q, period_d;
  logic [2:0] timer_q, timer_d;

  always_comb begin
    nrx2_d   = nrx2_q;
    vol_d    = vol_q;
    up_d     = up_q;
    period_d = period_q;
    timer_d  = timer_q;
    if (bus.reg_we && bus.reg_addr == REG_ADDR) nrx2_d = bus.reg_data;
    // Register contents only reach the live envelope on a trigger.
    if (trigger) begin
      vol_d    = nrx2_q[7:4];
      up_d     = nrx2_q[3];
      period_d = nrx2_q[2:0];
      timer_d  = nrx2_q[2:0];
    end else if (bus.tick_env && period_q != 3'd0) begin
      if (timer_q <= 3'd1) begin
        timer_d = period_q;
        if (up_q && vol_q != 4'hF)       vol_d = vol_q + 4'd1;
        else if (!up_q && vol_q != 4'h0) vol_d = vol_q - 4'd1;
      end else begin
        timer_d = timer_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nrx2_q   <= '0;
      vol_q    <= '0;
      up_q     <= 1'b0;
      period_q <= '0;
      timer_q  <= '0;
    end else begin
      nrx2_q   <= nrx2_d;
      vol_q    <= vol_d;
      up_q     <= up_d;
      period_q <= period_d;
      timer_q  <= timer_d;
    end
  end

  assign volume = vol_q;
  assign dac_on = (nrx2_q[7:3] != 5'd0);

endmodule

// File: rtl/sound_noise_channel.sv
// Noise channel: 15/7-bit LFSR clocked by a programmable timer, length counter and envelope.
// Define SND_NOISE_SIGNED_EN for a two's-complement O_SAMPLE; default is unsigned.
module sound_noise_channel
  import snd_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int TIMER_W  = 20
) (
  input  logic                I_CLK,
  input  logic                I_RESET_L,
  input  logic [1:0]          I_REG_ADDR,
  input  logic [7:0]          I_REG_DATA,
  input  logic                I_REG_WE,
  input  logic                I_TICK_CH,
  input  logic                I_TICK_LEN,
  input  logic                I_TICK_ENV,
  output logic [SAMPLE_W-1:0] O_SAMPLE,
  output logic                O_ACTIVE,
  output logic                O_LFSR_BIT
);

  sound_noise_channel_if bus_if ();
  assign bus_if.reg_addr = I_REG_ADDR;
  assign bus_if.reg_data = I_REG_DATA;
  assign bus_if.reg_we   = I_REG_WE;
  assign bus_if.tick_ch  = I_TICK_CH;
  assign bus_if.tick_len = I_TICK_LEN;
  assign bus_if.tick_env = I_TICK_ENV;

  logic [7:0]          nr43_q, nr43_d;
  logic [7:0]          cfg_q, cfg_d;
  logic                len_en_q, len_en_d;
  logic [6:0]          len_cnt_q, len_cnt_d;
  logic                active_q, active_d;
  logic [14:0]         lfsr_q, lfsr_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;

  logic [3:0]          volume;
  logic                dac_on;
  logic                wr_nr41, wr_nr42, wr_nr43, wr_nr44, trigger;
  logic                lfsr_x;
  logic [14:0]         lfsr_step;
  logic [TIMER_W-1:0]  trig_period, run_period;
  logic [SAMPLE_W-1:0] mag;

  assign wr_nr41 = I_REG_WE && I_REG_ADDR == ADDR_NR41;
  assign wr_nr42 = I_REG_WE && I_REG_ADDR == ADDR_NR42;
  assign wr_nr43 = I_REG_WE && I_REG_ADDR == ADDR_NR43;
  assign wr_nr44 = I_REG_WE && I_REG_ADDR == ADDR_NR44;
  assign trigger = wr_nr44 && I_REG_DATA[7];

  assign trig_period = TIMER_W'(noise_period(nr43_q[7:4], nr43_q[2:0]));
  assign run_period  = TIMER_W'(noise_period(cfg_q[7:4], cfg_q[2:0]));

  snd_envelope #(.REG_ADDR(ADDR_NR42)) u_env (
    .clk     (I_CLK),
    .rst_n   (I_RESET_L),
    .bus     (bus_if.slave),
    .trigger (trigger),
    .volume  (volume),
    .dac_on  (dac_on)
  );

  always_comb begin
    lfsr_x    = lfsr_q[0] ^ lfsr_q[1];
    lfsr_step = {lfsr_x, lfsr_q[14:1]};
    if (cfg_q[3]) lfsr_step[6] = lfsr_x;
  end

  always_comb begin
    nr43_d    = nr43_q;
    cfg_d     = cfg_q;
    len_en_d  = len_en_q;
    len_cnt_d = len_cnt_q;
    active_d  = active_q;
    lfsr_d    = lfsr_q;
    timer_d   = timer_q;
    if (wr_nr43) nr43_d   = I_REG_DATA;
    if (wr_nr44) len_en_d = I_REG_DATA[6];

    // An NR41 load beats the length tick; a trigger only refills an exhausted counter.
    if (wr_nr41) begin
      len_cnt_d = 7'd64 - {1'b0, I_REG_DATA[5:0]};
    end else if (trigger) begin
      if (len_cnt_q == 7'd0) len_cnt_d = 7'd64;
    end else if (I_TICK_LEN && len_en_q && len_cnt_q != 7'd0) begin
      len_cnt_d = len_cnt_q - 7'd1;
      if (len_cnt_q == 7'd1) active_d = 1'b0;
    end
    if (wr_nr42 && I_REG_DATA[7:3] == 5'd0) active_d = 1'b0;
    if (trigger) active_d = dac_on;

    // Shifts 14 and 15 freeze the LFSR entirely.
    if (trigger) begin
      cfg_d   = nr43_q;
      lfsr_d  = LFSR_SEED;
      timer_d = trig_period;
    end else if (active_q && I_TICK_CH && cfg_q[7:4] < 4'd14) begin
      if (timer_q <= TIMER_W'(1)) begin
        timer_d = run_period;
        lfsr_d  = lfsr_step;
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
  end

`ifdef SND_NOISE_SIGNED_EN
  always_comb begin
    mag      = SAMPLE_W'(volume) << (SAMPLE_W - 5);
    sample_d = '0;
    if (active_q) sample_d = lfsr_q[0] ? (~mag + SAMPLE_W'(1)) : mag;
  end
`else
  always_comb begin
    mag      = SAMPLE_W'(volume) << (SAMPLE_W - 4);
    sample_d = (active_q && !lfsr_q[0]) ? mag : '0;
  end
`endif

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      nr43_q    <= '0;
      cfg_q     <= '0;
      len_en_q  <= 1'b0;
      len_cnt_q <= '0;
      active_q  <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      timer_q   <= '0;
      sample_q  <= '0;
    end else begin
      nr43_q    <= nr43_d;
      cfg_q     <= cfg_d;
      len_en_q  <= len_en_d;
      len_cnt_q <= len_cnt_d;
      active_q  <= active_d;
      lfsr_q    <= lfsr_d;
      timer_q   <= timer_d;
      sample_q  <= sample_d;
    end
  end

  assign O_SAMPLE   = sample_q;
  assign O_ACTIVE   = active_q;
  assign O_LFSR_BIT = ~lfsr_q[0];

endmodule
